// File: rtl/clk_div_ctrl.sv
// Divider ratio/enable controller: accepts config requests, and while the divider runs it
// defers the output update to a falling edge of the divided clock, forcing it on timeout.
module clk_div_ctrl #(
   parameter logic [4:0]  RST_RATIO   = 5'd2,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic       i_ref_clk,
   input  logic       i_rst,
   input  logic       i_cfg_valid,
   input  logic [4:0] i_cfg_ratio,
   input  logic       i_cfg_en,
   input  logic       i_div_clk,
   output logic       o_cfg_ready,
   output logic [4:0] o_div_ratio,
   output logic       o_clk_en,
   output logic       o_cfg_err,
   output logic       o_timeout
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_FALL = 2'd1,
      SETTLE    = 2'd2
   } state_e;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [3:0] ST_LAST = 4'(SETTLE_CYC - 1);

   state_e     state_q;
   logic [4:0] pend_ratio_q;
   logic       pend_en_q;
   logic [7:0] to_cnt_q;
   logic [3:0] st_cnt_q;
   logic       div_q;
   logic [4:0] div_ratio_q;
   logic       clk_en_q;
   logic       cfg_ready_q;
   logic       cfg_err_q;
   logic       timeout_q;

   logic hs_d, bad_cfg_d, fall_d, to_hit_d;

   assign hs_d      = i_cfg_valid & cfg_ready_q;
   assign bad_cfg_d = i_cfg_en & (i_cfg_ratio < 5'd2);
   assign fall_d    = div_q & ~i_div_clk;
   assign to_hit_d  = (to_cnt_q == TO_LAST);

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         pend_ratio_q <= '0;
         pend_en_q    <= 1'b0;
         to_cnt_q     <= '0;
         st_cnt_q     <= '0;
         div_q        <= 1'b0;
         div_ratio_q  <= RST_RATIO;
         clk_en_q     <= 1'b0;
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         div_q     <= i_div_clk;
         cfg_err_q <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hs_d) begin
                  if (bad_cfg_d) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     pend_ratio_q <= i_cfg_ratio;
                     pend_en_q    <= i_cfg_en;
                     cfg_ready_q  <= 1'b0;
                     // A stopped divider has no glitch risk, so update straight away.
                     if (!clk_en_q) begin
                        div_ratio_q <= i_cfg_ratio;
                        clk_en_q    <= i_cfg_en;
                        st_cnt_q    <= '0;
                        state_q     <= SETTLE;
                     end else begin
                        to_cnt_q <= '0;
                        state_q  <= WAIT_FALL;
                     end
                  end
               end
            end
            WAIT_FALL: begin
               if (fall_d || to_hit_d) begin
                  div_ratio_q <= pend_ratio_q;
                  clk_en_q    <= pend_en_q;
                  timeout_q   <= ~fall_d;
                  st_cnt_q    <= '0;
                  state_q     <= SETTLE;
               end else if (to_cnt_q != 8'hFF) begin
                  to_cnt_q <= to_cnt_q + 8'd1;
               end
            end
            SETTLE: begin
               if (st_cnt_q == ST_LAST) begin
                  state_q     <= IDLE;
                  cfg_ready_q <= 1'b1;
               end else begin
                  st_cnt_q <= st_cnt_q + 4'd1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cfg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_cfg_ready = cfg_ready_q;
   assign o_div_ratio = div_ratio_q;
   assign o_clk_en    = clk_en_q;
   assign o_cfg_err   = cfg_err_q;
   assign o_timeout   = timeout_q;

endmodule
